// File: rtl/dma_defs.sv
// Shared definitions for the DMA channel arbiter: FSM state encodings and default burst length.
// No logic here, so there is no latency.
// No flow control here either; this file only carries types and constants.
package dma_defs;

  // Arbiter FSM states; the encodings are fixed so debug taps and status reads stay stable.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_XFER = 2'b01,
    ARB_REL  = 2'b10
  } arb_state_t;

  // Default maximum number of beats per grant.
  localparam int DMA_BURST = 4;

  // Width of a channel index for a given channel count (at least 1 bit).
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/dma_rr_pick.sv
// Round-robin picker: first eligible channel searching upward from rr_ptr, wrapping modulo NUM_CH.
// Purely combinational, zero cycles.
// No backpressure; a pick is reported whenever any elig bit is set.
module dma_rr_pick
  import dma_defs::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = ch_idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] elig,
  input  logic [IDX_W-1:0]  rr_ptr,
  output logic              pick_vld,
  output logic [NUM_CH-1:0] pick_oh,
  output logic [IDX_W-1:0]  pick_idx
);

  // Walk the channels in priority order starting at rr_ptr; the first eligible one wins.
  always_comb begin
    int j;
    logic found;
    logic [IDX_W-1:0] idx;
    pick_oh  = '0;
    pick_idx = '0;
    found    = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_CH) begin
        j = j - NUM_CH;
      end
      idx = IDX_W'(j);
      if (!found && elig[idx]) begin
        found         = 1'b1;
        pick_oh[idx]  = 1'b1;
        pick_idx      = idx;
      end
    end
    pick_vld = found;
  end

endmodule

// File: rtl/dma_chan_arb.sv
// Round-robin DMA channel arbiter: grants one eligible channel to the AHB master for up to BURST beats.
// Grant and req are registered one edge after eligibility is seen in IDLE; minimum 2-cycle gap between bursts.
// A burst ends at a beat boundary when the count reaches BURST or the granted channel loses flow control.
module dma_chan_arb
  import dma_defs::*;
#(
  parameter int NUM_CH = 4,
  parameter int BURST  = DMA_BURST,
  parameter int CNT_W  = 4
) (
  input  logic              hclk,
  input  logic              n_hreset,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic [NUM_CH-1:0] ch_slot_av,
  input  logic [NUM_CH-1:0] ch_data_av,
  input  logic [NUM_CH-1:0] ch_word_av,
  input  logic              beat_done,
  output logic              req,
  output logic [NUM_CH-1:0] grant,
  output logic              size_word,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              busy
);

  localparam int IDX_W = ch_idx_w(NUM_CH);

  // The counter compare is done one bit wider so BURST == 2**CNT_W still terminates correctly.
  localparam logic [CNT_W:0] BURST_X = (CNT_W + 1)'(BURST);

  arb_state_t        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [NUM_CH-1:0] elig;
  logic              elig_gnt;
  logic              pick_vld;
  logic [NUM_CH-1:0] pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  rr_next;
  logic [CNT_W:0]    cnt_inc;
  logic              burst_end;

  // A channel may be granted only when enabled, its source has data and its destination has room.
  always_comb begin
    elig     = ch_enable & ch_slot_av & ch_data_av;
    elig_gnt = |(elig & grant);
  end

  dma_rr_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_pick (
    .elig     (elig),
    .rr_ptr   (rr_ptr),
    .pick_vld (pick_vld),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx)
  );

  // Next pointer is the slot after the winner, so the winner has lowest priority next time.
  always_comb begin
    if (pick_idx == IDX_W'(NUM_CH - 1)) begin
      rr_next = '0;
    end else begin
      rr_next = pick_idx + IDX_W'(1);
    end
  end

  // Beat count after the current beat, and whether that beat closes the burst.
  always_comb begin
    cnt_inc   = {1'b0, beat_cnt} + (CNT_W + 1)'(1);
    burst_end = (cnt_inc >= BURST_X) || !elig_gnt;
  end

  // Arbiter FSM with registered outputs; a reset mid-burst drops everything immediately.
  always_ff @(posedge hclk or negedge n_hreset) begin
    if (!n_hreset) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      req       <= 1'b0;
      grant     <= '0;
      size_word <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_vld) begin
            grant     <= pick_oh;
            size_word <= |(ch_word_av & pick_oh);
            beat_cnt  <= '0;
            req       <= 1'b1;
            rr_ptr    <= rr_next;
            state     <= ARB_XFER;
          end
        end
        ARB_XFER: begin
          // Eligibility is only looked at on a beat boundary; an in-flight beat always completes.
          if (beat_done) begin
            if ({1'b0, beat_cnt} < BURST_X) begin
              beat_cnt <= cnt_inc[CNT_W-1:0];
            end
            if (burst_end) begin
              req   <= 1'b0;
              state <= ARB_REL;
            end
          end
        end
        ARB_REL: begin
          // One quiet cycle lets the peripheral flow lines settle before re-arbitration.
          grant <= '0;
          state <= ARB_IDLE;
        end
        default: begin
          req   <= 1'b0;
          grant <= '0;
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  // Busy follows the registered state directly.
  always_comb begin
    busy = (state != ARB_IDLE);
  end

endmodule
